innings_sequencer: RTL

- Match-flow controller and producer of the delivery / teamSwitch / inningOver / gameOver signals consumed by the LED ball counter.
- Turns a synchronised bowl push-button into single-cycle delivery pulses, each paired with a held LFSR sample.
- Decodes each outcome into runs, wicket and legal-ball effects, keeps per-team tallies, and sequences team 1 innings → changeover → team 2 chase → game over.

---
 rtl/cricket_pkg.sv | 22 ++
 rtl/delivery_outcome_decode.sv | 33 +++
 rtl/innings_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cricket_pkg.sv
// Shared definitions for the cricket match controller: outcome codes,
// match-flow states and winner encodings.
package cricket_pkg;

  localparam logic [3:0] CODE_WICKET_A = 4'd12;
  localparam logic [3:0] CODE_WIDE     = 4'd13;
  localparam logic [3:0] CODE_NOBALL   = 4'd14;
  localparam logic [3:0] CODE_WICKET_B = 4'd15;

  typedef enum logic [1:0] {
    T1_BAT    = 2'd0,
    T1_DONE   = 2'd1,
    T2_BAT    = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'd0;
  localparam logic [1:0] WIN_TEAM1 = 2'd1;
  localparam logic [1:0] WIN_TEAM2 = 2'd2;
  localparam logic [1:0] WIN_TIE   = 2'd3;

endpackage

// File: rtl/delivery_outcome_decode.sv
// Maps a 4-bit outcome code to runs scored, wicket flag and whether the
// ball counts toward the innings' legal-ball allowance.
module delivery_outcome_decode
  import cricket_pkg::*;
(
  input  logic [3:0] code,
  output logic [2:0] runs,
  output logic       is_wicket,
  output logic       is_legal
);

  // Pure lookup; extras (wide/no ball) score one run but are not legal balls.
  always_comb begin
    runs      = 3'd0;
    is_wicket = 1'b0;
    is_legal  = 1'b1;
    case (code)
      4'd0, 4'd1, 4'd2:             runs = 3'd0;
      4'd3, 4'd4, 4'd5:             runs = 3'd1;
      4'd6, 4'd7:                   runs = 3'd2;
      4'd8:                         runs = 3'd3;
      4'd9, 4'd10:                  runs = 3'd4;
      4'd11:                        runs = 3'd6;
      CODE_WICKET_A, CODE_WICKET_B: is_wicket = 1'b1;
      CODE_WIDE, CODE_NOBALL: begin
        runs     = 3'd1;
        is_legal = 1'b0;
      end
      default: runs = 3'd0;
    endcase
  end

endmodule

// File: rtl/innings_sequencer.sv
// Match-flow controller: turns bowl button presses into delivery pulses,
// scores each delivery and walks team 1 innings -> changeover -> team 2
// chase -> game over.
module innings_sequencer
  import cricket_pkg::*;
#(
  parameter int MAX_BALLS   = 30,
  parameter int MAX_WICKETS = 10,
  parameter int RUN_W       = 9
) (
  input  logic             clk_fpga,
  input  logic             reset,
  input  logic             bowl_btn,
  input  logic [3:0]       lfsr_out,
  output logic             delivery,
  output logic [3:0]       lfsr_sample,
  output logic             teamSwitch,
  output logic             inningOver,
  output logic             gameOver,
  output logic [RUN_W-1:0] team1Runs,
  output logic [RUN_W-1:0] team2Runs,
  output logic [3:0]       team1Wkts,
  output logic [3:0]       team2Wkts,
  output logic [1:0]       winner
);

  state_t           state, next_state;
  logic [1:0]       next_winner;
  logic             btn_q;
  logic             press;
  logic             batting;
  logic             launch;
  logic [6:0]       balls;
  logic [2:0]       dec_runs;
  logic             dec_wicket;
  logic             dec_legal;
  logic [RUN_W-1:0] cur_runs;
  logic [3:0]       cur_wkts;
  logic [RUN_W:0]   run_sum;
  logic [RUN_W-1:0] upd_runs;
  logic [3:0]       upd_wkts;
  logic [6:0]       upd_balls;
  logic             limit_hit;
  logic             chase_done;

  delivery_outcome_decode u_decode (
    .code      (lfsr_sample),
    .runs      (dec_runs),
    .is_wicket (dec_wicket),
    .is_legal  (dec_legal)
  );

  assign press   = bowl_btn & ~btn_q;
  assign batting = (state == T1_BAT) || (state == T2_BAT);
  assign launch  = press & batting & ~delivery;

  // Tallies after the in-flight delivery is applied, saturating the run total.
  always_comb begin
    cur_runs   = (state == T2_BAT) ? team2Runs : team1Runs;
    cur_wkts   = (state == T2_BAT) ? team2Wkts : team1Wkts;
    run_sum    = {1'b0, cur_runs} + {{(RUN_W-2){1'b0}}, dec_runs};
    upd_runs   = run_sum[RUN_W] ? {RUN_W{1'b1}} : run_sum[RUN_W-1:0];
    upd_wkts   = cur_wkts + {3'b000, dec_wicket};
    upd_balls  = balls + {6'b000000, dec_legal};
    limit_hit  = (upd_balls == 7'(MAX_BALLS)) || (upd_wkts == 4'(MAX_WICKETS));
    chase_done = (upd_runs > team1Runs);
  end

  // Button edge register, delivery launch and per-team scoring.
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      btn_q       <= 1'b0;
      delivery    <= 1'b0;
      lfsr_sample <= 4'd0;
      team1Runs   <= '0;
      team2Runs   <= '0;
      team1Wkts   <= 4'd0;
      team2Wkts   <= 4'd0;
      balls       <= 7'd0;
    end else begin
      btn_q    <= bowl_btn;
      delivery <= launch;
      if (launch)
        lfsr_sample <= lfsr_out;
      if (delivery) begin
        balls <= upd_balls;
        if (state == T2_BAT) begin
          team2Runs <= upd_runs;
          team2Wkts <= upd_wkts;
        end else begin
          team1Runs <= upd_runs;
          team1Wkts <= upd_wkts;
        end
      end
      if ((state == T1_DONE) && press)
        balls <= 7'd0;
    end
  end

  // Match-flow state and latched winner.
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state  <= T1_BAT;
      winner <= WIN_NONE;
    end else begin
      state  <= next_state;
      winner <= next_winner;
    end
  end

  // Next-state decisions; a successful chase outranks a simultaneous limit.
  always_comb begin
    next_state  = state;
    next_winner = winner;
    teamSwitch  = 1'b0;
    inningOver  = 1'b0;
    gameOver    = 1'b0;
    case (state)
      T1_BAT: begin
        if (delivery && limit_hit)
          next_state = T1_DONE;
      end
      T1_DONE: begin
        inningOver = 1'b1;
        if (press)
          next_state = T2_BAT;
      end
      T2_BAT: begin
        teamSwitch = 1'b1;
        if (delivery) begin
          if (chase_done) begin
            next_state  = GAME_OVER;
            next_winner = WIN_TEAM2;
          end else if (limit_hit) begin
            next_state  = GAME_OVER;
            next_winner = (team1Runs > upd_runs) ? WIN_TEAM1 : WIN_TIE;
          end
        end
      end
      GAME_OVER: begin
        teamSwitch = 1'b1;
        inningOver = 1'b1;
        gameOver   = 1'b1;
      end
      default: next_state = T1_BAT;
    endcase
  end

endmodule
